// File: rtl/infernet_ctrl_pkg.sv
// Types shared by the loop-controller family (sequencers, address walkers).
package infernet_ctrl_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_RUN,
      SEQ_FINISH
   } seq_state_t;

endpackage

// File: rtl/mac_loop_sequencer_wrap_counter.sv
// Index counter that wraps to zero at a programmable limit; synchronous clear wins over enable.
module wrap_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CLEAR,
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] LIMIT,
   output logic [WIDTH-1:0] VALUE,
   output logic             AT_LIMIT
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   assign AT_LIMIT = (VALUE == LIMIT);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         VALUE <= '0;
      end else if (CLEAR) begin
         VALUE <= '0;
      end else if (ENABLE) begin
         VALUE <= AT_LIMIT ? '0 : VALUE + ONE;
      end
   end

endmodule

// File: rtl/mac_loop_sequencer.sv
// Row x col loop-nest sequencer: one (row,col) beat per handshake, then a DONE pulse.
module mac_loop_sequencer #(
   parameter int unsigned ROW_WIDTH = 8,
   parameter int unsigned COL_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic [ROW_WIDTH-1:0] ROWS,
   input  logic [COL_WIDTH-1:0] COLS,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [ROW_WIDTH-1:0] ROW_IDX,
   output logic [COL_WIDTH-1:0] COL_IDX,
   output logic                 LAST_COL,
   output logic                 LAST
);

   import infernet_ctrl_pkg::*;

   localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);
   localparam logic [COL_WIDTH-1:0] COL_ONE = COL_WIDTH'(1);

   seq_state_t state, state_nxt;

   logic [ROW_WIDTH-1:0] rows_q, row_lim, row_val, row_nxt;
   logic [COL_WIDTH-1:0] cols_q, col_lim, col_val, col_nxt;
   logic                 row_at_lim, col_at_lim;
   logic                 advance, cnt_clear;
   logic                 busy_q, done_q, valid_q, last_col_q, last_q;
   logic                 busy_d, done_d, valid_d, last_col_d, last_d;

   assign row_lim = rows_q - ROW_ONE;
   assign col_lim = cols_q - COL_ONE;

   // ABORT outranks a coincident handshake: the beat is dropped, not counted.
   assign advance   = (state == SEQ_RUN) && valid_q && OUT_READY && !ABORT;
   assign cnt_clear = (state != SEQ_RUN) || ABORT;

   wrap_counter #(.WIDTH(COL_WIDTH)) u_col_cnt (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .CLEAR    (cnt_clear),
      .ENABLE   (advance),
      .LIMIT    (col_lim),
      .VALUE    (col_val),
      .AT_LIMIT (col_at_lim)
   );

   wrap_counter #(.WIDTH(ROW_WIDTH)) u_row_cnt (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .CLEAR    (cnt_clear),
      .ENABLE   (advance && col_at_lim),
      .LIMIT    (row_lim),
      .VALUE    (row_val),
      .AT_LIMIT (row_at_lim)
   );

   // Indices the counters will hold after this beat, so LAST/LAST_COL can be registered.
   assign col_nxt = col_at_lim ? '0 : col_val + COL_ONE;
   assign row_nxt = col_at_lim ? (row_at_lim ? '0 : row_val + ROW_ONE) : row_val;

   always_comb begin
      state_nxt  = state;
      last_col_d = last_col_q;
      last_d     = last_q;
      unique case (state)
         SEQ_IDLE: begin
            last_col_d = 1'b0;
            last_d     = 1'b0;
            if (START) begin
               if ((ROWS != '0) && (COLS != '0)) begin
                  state_nxt  = SEQ_RUN;
                  last_col_d = (COLS == COL_ONE);
                  last_d     = (ROWS == ROW_ONE) && (COLS == COL_ONE);
               end else begin
                  state_nxt = SEQ_FINISH;
               end
            end
         end
         SEQ_RUN: begin
            if (ABORT) begin
               state_nxt  = SEQ_IDLE;
               last_col_d = 1'b0;
               last_d     = 1'b0;
            end else if (advance) begin
               if (last_q) begin
                  state_nxt  = SEQ_FINISH;
                  last_col_d = 1'b0;
                  last_d     = 1'b0;
               end else begin
                  last_col_d = (col_nxt == col_lim);
                  last_d     = (col_nxt == col_lim) && (row_nxt == row_lim);
               end
            end
         end
         SEQ_FINISH: begin
            state_nxt  = SEQ_IDLE;
            last_col_d = 1'b0;
            last_d     = 1'b0;
         end
         default: begin
            state_nxt  = SEQ_IDLE;
            last_col_d = 1'b0;
            last_d     = 1'b0;
         end
      endcase
      valid_d = (state_nxt == SEQ_RUN);
      done_d  = (state_nxt == SEQ_FINISH);
      busy_d  = (state_nxt != SEQ_IDLE);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= SEQ_IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         last_col_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         last_col_q <= last_col_d;
         last_q     <= last_d;
         if ((state == SEQ_IDLE) && START) begin
            rows_q <= ROWS;
            cols_q <= COLS;
         end
      end
   end

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign OUT_VALID = valid_q;
   assign ROW_IDX   = row_val;
   assign COL_IDX   = col_val;
   assign LAST_COL  = last_col_q;
   assign LAST      = last_q;

endmodule

// File: tb/tb_mac_loop_sequencer.sv
// Directed bench for mac_loop_sequencer: hand-computed beats, back-pressure, abort, reset, max size.
module tb_mac_loop_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic [7:0] rows;
   logic [7:0] cols;
   logic       busy;
   logic       done;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] row_idx;
   logic [7:0] col_idx;
   logic       last_col;
   logic       last;

   int checks = 0;
   int errors = 0;

   mac_loop_sequencer #(.ROW_WIDTH(8), .COL_WIDTH(8)) dut (
      .CLK       (clk),
      .RESET_N   (reset_n),
      .START     (start),
      .ABORT     (abort),
      .ROWS      (rows),
      .COLS      (cols),
      .BUSY      (busy),
      .DONE      (done),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .ROW_IDX   (row_idx),
      .COL_IDX   (col_idx),
      .LAST_COL  (last_col),
      .LAST      (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      rows = 8'd0; cols = 8'd0;
      tick(); tick();
      checks++;
      if ({busy, done, out_valid, last_col, last, row_idx, col_idx} !== 21'h0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", {busy, done, out_valid, last_col, last, row_idx, col_idx}, 21'h0);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_2x3();
      int er[6];
      int ec[6];
      int busy_cycles;
      er = '{0, 0, 0, 1, 1, 1};
      ec = '{0, 1, 2, 0, 1, 2};
      busy_cycles = 0;
      start = 1'b1; rows = 8'd2; cols = 8'd3; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 6; b++) begin
         checks++;
         if ({out_valid, row_idx, col_idx, last_col, last, done, busy} !==
             {1'b1, 8'(er[b]), 8'(ec[b]), (b == 2 || b == 5), (b == 5), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL basic_beat%0d got v=%b r=%0d c=%0d lc=%b l=%b d=%b bz=%b exp r=%0d c=%0d",
                     b, out_valid, row_idx, col_idx, last_col, last, done, busy, er[b], ec[b]);
         end
         busy_cycles += int'(busy);
         tick();
      end
      checks++;
      if ({out_valid, done, busy} !== 3'b011) begin
         errors++;
         $display("FAIL basic_finish got v/d/bz=%b exp=011", {out_valid, done, busy});
      end
      busy_cycles += int'(busy);
      tick();
      checks++;
      if ({out_valid, done, busy} !== 3'b000) begin
         errors++;
         $display("FAIL basic_idle got v/d/bz=%b exp=000", {out_valid, done, busy});
      end
      checks++;
      if (busy_cycles !== 7) begin
         errors++;
         $display("FAIL basic_busy_len got=%0d exp=7", busy_cycles);
      end
   endtask

   task automatic test_backpressure();
      int k;
      int done_cnt;
      logic ready;
      k = 0;
      done_cnt = 0;
      start = 1'b1; rows = 8'd2; cols = 8'd2;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
         ready = (cyc % 3 == 0);
         checks++;
         if ({out_valid, row_idx, col_idx, last_col, last, done} !==
             {1'b1, 8'(k / 2), 8'(k % 2), (k % 2 == 1), (k == 3), 1'b0}) begin
            errors++;
            $display("FAIL bp_cycle%0d got v=%b r=%0d c=%0d lc=%b l=%b d=%b exp beat %0d",
                     cyc, out_valid, row_idx, col_idx, last_col, last, done, k);
         end
         out_ready = ready;
         tick();
         if (ready) k++;
      end
      checks++;
      if (k !== 4) begin
         errors++;
         $display("FAIL bp_beat_count got=%0d exp=4", k);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_valid_after_last got=%b exp=0", out_valid);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         done_cnt += int'(done);
         tick();
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL bp_done_count got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_zero_size();
      logic [7:0] zr[2];
      logic [7:0] zc[2];
      zr = '{8'd0, 8'd4};
      zc = '{8'd5, 8'd0};
      for (int v = 0; v < 2; v++) begin
         start = 1'b1; rows = zr[v]; cols = zc[v];
         tick();
         start = 1'b0;
         checks++;
         if ({out_valid, done, busy} !== 3'b011) begin
            errors++;
            $display("FAIL zero%0d_finish got v/d/bz=%b exp=011", v, {out_valid, done, busy});
         end
         tick();
         checks++;
         if ({out_valid, done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL zero%0d_idle got v/d/bz=%b exp=000", v, {out_valid, done, busy});
         end
      end
   endtask

   task automatic test_start_ignored();
      int beats;
      int dones;
      int max_col;
      beats = 0; dones = 0; max_col = 0;
      start = 1'b1; rows = 8'd1; cols = 8'd3; out_ready = 1'b1;
      tick();
      rows = 8'd5; cols = 8'd5;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_valid && out_ready) begin
            beats++;
            if (int'(col_idx) > max_col) max_col = int'(col_idx);
         end
         dones += int'(done);
         start = busy;
         if (!busy) break;
         tick();
      end
      start = 1'b0;
      tick();
      checks++;
      if (beats !== 3) begin
         errors++;
         $display("FAIL ign_beats got=%0d exp=3", beats);
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL ign_dones got=%0d exp=1", dones);
      end
      checks++;
      if (max_col !== 2) begin
         errors++;
         $display("FAIL ign_max_col got=%0d exp=2", max_col);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_no_queue busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_abort();
      start = 1'b1; rows = 8'd3; cols = 8'd4; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 4; b++) tick();
      checks++;
      if ({out_valid, row_idx, col_idx} !== {1'b1, 8'd1, 8'd0}) begin
         errors++;
         $display("FAIL abort_beat5 got v=%b r=%0d c=%0d exp v=1 r=1 c=0", out_valid, row_idx, col_idx);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({busy, done, out_valid, last_col, last, row_idx, col_idx} !== 21'h0) begin
         errors++;
         $display("FAIL abort_idle got=%h exp=%h", {busy, done, out_valid, last_col, last, row_idx, col_idx}, 21'h0);
      end
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL abort_no_done got bz/d=%b exp=00", {busy, done});
      end
      start = 1'b1; rows = 8'd1; cols = 8'd1;
      tick();
      start = 1'b0;
      checks++;
      if ({out_valid, row_idx, col_idx, last_col, last} !== {1'b1, 8'd0, 8'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL one_by_one got v=%b r=%0d c=%0d lc=%b l=%b exp 1 0 0 1 1",
                  out_valid, row_idx, col_idx, last_col, last);
      end
      abort = 1'b1;
      out_ready = 1'b0;
      tick();
      abort = 1'b0;
      checks++;
      if ({busy, out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL abort_1x1 got bz/v=%b exp=00", {busy, out_valid});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if ({out_valid, done, busy} !== 3'b011) begin
         errors++;
         $display("FAIL one_by_one_done got v/d/bz=%b exp=011", {out_valid, done, busy});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({out_valid, done, busy} !== 3'b000) begin
         errors++;
         $display("FAIL abort_in_finish got v/d/bz=%b exp=000", {out_valid, done, busy});
      end
   endtask

   task automatic test_reset_and_max();
      int k;
      int dones;
      int bad;
      logic [7:0] lr;
      logic [7:0] lc;
      logic seen_last;
      start = 1'b1; rows = 8'd255; cols = 8'd255; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 300; i++) tick();
      reset_n = 1'b0;
      #2;
      checks++;
      if ({busy, done, out_valid, last_col, last, row_idx, col_idx} !== 21'h0) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", {busy, done, out_valid, last_col, last, row_idx, col_idx}, 21'h0);
      end
      #1;
      reset_n = 1'b1;
      tick();
      k = 0; dones = 0; bad = 0; lr = '0; lc = '0; seen_last = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 70000; cyc++) begin
         dones += int'(done);
         if (out_valid) begin
            if (row_idx !== 8'(k / 255) || col_idx !== 8'(k % 255) || last !== (k == 65024)) begin
               if (bad == 0) $display("beat %0d off: r=%0d c=%0d l=%b", k, row_idx, col_idx, last);
               bad++;
            end
            if (last) begin
               seen_last = 1'b1; lr = row_idx; lc = col_idx;
            end
            k++;
         end
         if (!busy) break;
         tick();
      end
      checks++;
      if (k !== 65025) begin
         errors++;
         $display("FAIL max_beats got=%0d exp=65025", k);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL max_sequence bad_beats got=%0d exp=0", bad);
      end
      checks++;
      if ({seen_last, lr, lc} !== {1'b1, 8'd254, 8'd254}) begin
         errors++;
         $display("FAIL max_last got seen=%b r=%0d c=%0d exp 1 254 254", seen_last, lr, lc);
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL max_dones got=%0d exp=1", dones);
      end
   endtask

   initial begin
      test_reset();
      test_basic_2x3();
      test_backpressure();
      test_zero_size();
      test_start_ignored();
      test_abort();
      test_reset_and_max();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
